load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 34 +++
 rtl/load_store_unit_load_extend.sv | 25 ++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared processor definitions for the load/store path: RV32I width codes,
// LSU state encoding and the legality check applied at request handshake.
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned widths exist only for loads; stores above SW are all illegal.
   function automatic logic op_illegal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (funct3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = offset[0];
         F3_W:    bad = (offset != 2'b00);
         F3_BU:   bad = we;
         F3_HU:   bad = we | offset[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load data extraction: moves the addressed byte/halfword down to bit 0 and
// sign- or zero-extends it to 32 bits according to the load width code.
module load_extend
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (funct3)
         F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   result = {24'h000000, shifted[7:0]};
         F3_HU:   result = {16'h0000, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory operation at a time from execute, issues
// it to a request/grant memory port and returns a single-cycle completion.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_e  state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [CW-1:0] cnt;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;
   logic [31:0] load_data;
   logic [3:0]  be;
   logic [31:0] lane_wdata;
   logic        in_req;

   load_extend u_load_extend (
      .rdata  (mem_rdata_i),
      .offset (addr_q[1:0]),
      .funct3 (f3_q),
      .result (load_data)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         we_q        <= 1'b0;
         f3_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt         <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  we_q    <= req_we_i;
                  f3_q    <= req_funct3_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  if (op_illegal(req_we_i, req_funct3_i, addr_i[1:0])) begin
                     state       <= ST_RESP;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else begin
                     state <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (mem_gnt_i) begin
                  cnt <= '0;
                  if (we_q) begin
                     state       <= ST_RESP;
                     rsp_err_q   <= 1'b0;
                     rsp_rdata_q <= '0;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // A response landing on the final wait cycle still wins over the timeout.
               if (mem_rvalid_i) begin
                  state       <= ST_RESP;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= load_data;
               end else if (cnt == CNT_LAST) begin
                  state       <= ST_RESP;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_RESP: begin
               state       <= ST_IDLE;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      be         = 4'b1111;
      lane_wdata = wdata_q;
      if (we_q) begin
         case (f3_q)
            F3_B: begin
               be         = 4'b0001 << addr_q[1:0];
               lane_wdata = {4{wdata_q[7:0]}};
            end
            F3_H: begin
               be         = addr_q[1] ? 4'b1100 : 4'b0011;
               lane_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // Memory-side outputs are forced low outside REQ so idle/reset shows all zeros.
   assign in_req      = (state == ST_REQ);
   assign req_ready_o = (state == ST_IDLE);
   assign mem_req_o   = in_req;
   assign mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : '0;
   assign mem_we_o    = in_req & we_q;
   assign mem_be_o    = in_req ? be : '0;
   assign mem_wdata_o = (in_req & we_q) ? lane_wdata : '0;
   assign rsp_valid_o = (state == ST_RESP);
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule
